pal_number_generator: RTL and testbench

Sequential palindrome builder that mirrors the decimal digits of an input "half" value into a full palindromic number. It is the producer counterpart to the palindrome analyzer: its 32-bit output is intended to feed the analyzer's number input, and must always be reported palindromic. It processes one decimal digit per clock and holds its result until the next start.

---
 rtl/pal_pkg.sv | 20 ++
 rtl/pal_divmod10.sv | 19 +
 rtl/pal_number_generator.sv | 148 ++++++++++++++
 tb/tb_pal_number_generator.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pal_pkg
// Description : Shared constants for the palindrome generator/analyzer pair.
// Revision    : 1.0 - initial release
// ============================================================================
package pal_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CHK    = 3'd1;
    localparam logic [2:0] DROP   = 3'd2;
    localparam logic [2:0] MIRROR = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam logic [31:0] PAL_MAX_HALF = 32'd99999;
    localparam logic [31:0] PAL_MAX32    = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/pal_divmod10.sv
`default_nettype none
// ============================================================================
// Module      : pal_divmod10
// Description : Combinational unsigned divide/modulo by ten.
// Revision    : 1.0 - initial release
// ============================================================================
module pal_divmod10
    import pal_pkg::*;
(
    input  logic [31:0] dividend_i,
    output logic [31:0] quotient_o,
    output logic [3:0]  remainder_o
);

    assign quotient_o  = dividend_i / 32'd10;
    assign remainder_o = 4'(dividend_i % 32'd10);

endmodule
`default_nettype wire

// File: rtl/pal_number_generator.sv
`default_nettype none
// ============================================================================
// Module      : pal_number_generator
// Description : Builds a decimal palindrome from a half value, one digit/clock.
// Revision    : 1.0 - initial release
// ============================================================================
module pal_number_generator
    import pal_pkg::*;
#(
    parameter logic [31:0] MAX_HALF = PAL_MAX_HALF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [31:0] in_half,
    input  logic        odd_mode,
    output logic [31:0] out_number,
    output logic        out_ready,
    output logic        overflow,
    output logic        busy
);

    logic [2:0]  state_q, state_d;
    logic [31:0] num_q, num_d;
    logic [35:0] acc_q, acc_d;
    logic        mode_q, mode_d;
    logic        range_q, range_d;
    logic [31:0] out_number_q, out_number_d;
    logic        out_ready_q, out_ready_d;
    logic        overflow_q, overflow_d;
    logic        busy_q, busy_d;

    logic [31:0] w_quot;
    logic [3:0]  w_rem;

    pal_divmod10 u_divmod10 (
        .dividend_i  (num_q),
        .quotient_o  (w_quot),
        .remainder_o (w_rem)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) state_d = CHK;
                CHK: begin
                    if (num_q > MAX_HALF) state_d = FINISH;
                    else if (mode_q)      state_d = DROP;
                    else                  state_d = MIRROR;
                end
                DROP:   state_d = MIRROR;
                MIRROR: if (num_q == 32'd0) state_d = FINISH;
                FINISH: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        num_d        = num_q;
        acc_d        = acc_q;
        mode_d       = mode_q;
        range_d      = range_q;
        out_number_d = out_number_q;
        out_ready_d  = out_ready_q;
        overflow_d   = overflow_q;
        // busy is registered one state late so it falls together with out_ready rising
        busy_d       = enable && (state_q == CHK || state_q == DROP || state_q == MIRROR);
        if (!enable) begin
            out_number_d = 32'd0;
            out_ready_d  = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        num_d       = in_half;
                        acc_d       = {4'd0, in_half};
                        mode_d      = odd_mode;
                        range_d     = 1'b0;
                        out_ready_d = 1'b0;
                        overflow_d  = 1'b0;
                    end
                end
                CHK:  range_d = (num_q > MAX_HALF);
                DROP: num_d = w_quot;
                MIRROR: begin
                    if (num_q != 32'd0) begin
                        acc_d = acc_q * 36'd10 + {32'd0, w_rem};
                        num_d = w_quot;
                    end
                end
                FINISH: begin
                    out_ready_d = 1'b1;
                    if (range_q || (acc_q > {4'd0, PAL_MAX32})) begin
                        overflow_d   = 1'b1;
                        out_number_d = 32'd0;
                    end else begin
                        overflow_d   = 1'b0;
                        out_number_d = acc_q[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            num_q        <= 32'd0;
            acc_q        <= 36'd0;
            mode_q       <= 1'b0;
            range_q      <= 1'b0;
            out_number_q <= 32'd0;
            out_ready_q  <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            num_q        <= num_d;
            acc_q        <= acc_d;
            mode_q       <= mode_d;
            range_q      <= range_d;
            out_number_q <= out_number_d;
            out_ready_q  <= out_ready_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
        end
    end

    assign out_number = out_number_q;
    assign out_ready  = out_ready_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pal_number_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pal_number_generator
// Description : Directed scoreboard bench for the palindrome generator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pal_number_generator;

    typedef struct {
        logic [31:0] num;
        logic        ovf;
        int          lat;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        start;
    logic [31:0] in_half;
    logic        odd_mode;
    logic [31:0] out_number;
    logic        out_ready;
    logic        overflow;
    logic        busy;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    pal_number_generator dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .in_half    (in_half),
        .odd_mode   (odd_mode),
        .out_number (out_number),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t model(input logic [31:0] half, input logic odd);
        exp_t        e;
        int          digs[$];
        longint      v;
        logic [31:0] h;
        h = half;
        while (h != 0) begin
            digs.push_back(int'(h % 10));
            h = h / 10;
        end
        if (half > 32'd99999) begin
            e.num = 32'd0; e.ovf = 1'b1; e.lat = 2;
        end else begin
            v = longint'(half);
            for (int i = (odd ? 1 : 0); i < digs.size(); i++) v = v * 10 + digs[i];
            e.ovf = (v > 64'hFFFF_FFFF);
            e.num = e.ovf ? 32'd0 : v[31:0];
            e.lat = (odd && half == 0) ? 4 : digs.size() + 3;
        end
        return e;
    endfunction

    function automatic logic is_pal(input logic [31:0] x);
        longint f, r;
        f = longint'(x);
        r = 0;
        while (f != 0) begin
            r = r * 10 + (f % 10);
            f = f / 10;
        end
        return (r == longint'(x));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_num"},   out_number, 32'd0);
        check({tag, "_rdy"},   32'(out_ready), 32'd0);
        check({tag, "_ovf"},   32'(overflow), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    // disturb: 0 none, 1 start pulse mid-MIRROR, 2 reset mid-MIRROR, 3 enable low mid-MIRROR
    task automatic run(input logic [31:0] half, input logic odd, input int disturb);
        exp_t e;
        int   edges;
        bit   done;
        e = model(half, odd);
        if (disturb <= 1) sb.push_back(e);
        @(negedge clock);
        in_half = half; odd_mode = odd; start = 1'b1;
        @(posedge clock); #1;
        check("ready_drop", 32'(out_ready), 32'd0);
        check("ovf_drop", 32'(overflow), 32'd0);
        @(negedge clock);
        start = 1'b0; in_half = 32'hDEAD_BEEF; odd_mode = ~odd;
        edges = 1; done = 0;
        while (!done) begin
            @(posedge clock); #1;
            edges++;
            if (edges == 2) check("busy_rise", 32'(busy), 32'd1);
            if (disturb == 1 && edges == 4) begin
                start = 1'b1; in_half = 32'd11; odd_mode = 1'b1;
            end
            if (disturb == 1 && edges == 5) start = 1'b0;
            if (disturb == 2 && edges == 4) begin
                #2 reset = 1'b1;
                #1 outputs_zero("async_reset");
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            if (disturb == 3 && edges == 4) begin
                enable = 1'b0;
                @(posedge clock); #1;
                outputs_zero("enable_low");
                @(negedge clock);
                enable = 1'b1;
                return;
            end
            if (out_ready) begin
                done = 1;
            end else if (edges >= 20) begin
                vectors++;
                miscompares++;
                $error("FAIL timeout half=%0d observed=no_ready expected=ready", half);
                void'(sb.pop_front());
                return;
            end
        end
        e = sb.pop_front();
        check("latency", 32'(edges - 1), 32'(e.lat));
        check("number", out_number, e.num);
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("busy_fall", 32'(busy), 32'd0);
        check("is_pal", 32'(is_pal(out_number)), 32'd1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; start = 1'b0; in_half = 32'd0; odd_mode = 1'b0;
        #12;
        outputs_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        outputs_zero("idle");

        run(32'd12345, 1'b0, 0);
        repeat (3) @(posedge clock);
        #1;
        check("hold_rdy", 32'(out_ready), 32'd1);
        check("hold_num", out_number, 32'd1234554321);
        run(32'd123, 1'b1, 0);
        run(32'd7, 1'b0, 0);
        run(32'd7, 1'b1, 0);
        run(32'd0, 1'b0, 0);
        run(32'd0, 1'b1, 0);
        run(32'd42949, 1'b0, 0);
        run(32'd42949, 1'b1, 0);
        run(32'd100000, 1'b0, 0);
        run(32'd100000, 1'b1, 0);
        run(32'd99999, 1'b0, 0);
        run(32'd12345, 1'b0, 1);
        run(32'd12345, 1'b0, 2);
        run(32'd54321, 1'b1, 0);
        run(32'd12345, 1'b0, 3);
        run(32'd909, 1'b0, 0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
